mc_core_hs: RTL
===============

# mc_core_hs

Multicycle MIPS-subset core with its control sequencer built in. It exposes a single shared instruction/data memory port with a req/ack handshake, so memory may insert wait states. GPIO is memory-mapped instead of muxed into the immediate path, with parametrised width, reset vector and GPIO address. It adds a bus-timeout watchdog and a trap state for illegal opcodes and stalled buses.

## Interface
- WIDTH, 32: datapath, register and address width. Instructions are always 32 bits; WIDTH must be ≥ 32.
- GPIO_W, 16: width of gpio_i. Reads are zero-extended to WIDTH.
- RESET_PC, 0: PC value after reset.
- GPIO_ADDR, 32'hFFFF_0000: word address decoded for GPIO. Accesses to it never reach the memory port.
- TIMEOUT, 15: maximum wait cycles on mem_ack before a bus trap. 0 disables the watchdog.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier; valid only while mem_req=1.
- mem_addr  out  WIDTH  byte address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  completes the access on the edge where mem_req=1 and mem_ack=1. Zero-wait memory may tie it high.
- gpio_i  in  GPIO_W  input port.
- gpio_o  out  WIDTH  output register, written by sw to GPIO_ADDR.
- state_o  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- err_o  out  2  00 none, 01 illegal opcode, 10 bus timeout.

## Operation
- **Supported instructions:** R-type (op 0) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). Also addi 0x08, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- **Immediates:** addi, lw, sw and beq use sign-extended imm. ori uses zero-extended imm.
- **Register file:** 32 × WIDTH registers with internal registers IR, A, B, ALUOut and MDR. Writes to r0 are discarded, and r0 always reads 0.
- **FETCH:** drive mem_req=1, mem_we=0, mem_addr=PC. On ack: IR←mem_rdata, PC←PC+4, go to DECODE.
- **DECODE:** A←R[rs], B←R[rt]. Go to EXEC. An unsupported op or funct goes to TRAP with err_o=01 instead.
- **EXEC, R-type / addi / ori:** ALUOut←result, go to WB.
- **EXEC, lw / sw:** ALUOut←A+sext(imm), go to MEM.
- **EXEC, beq:** if A==B, PC←PC+(sext(imm)<<2), where PC is the already-incremented value. Go to FETCH.
- **EXEC, j:** PC←{PC[31:28], imm26, 2'b00}. Go to FETCH.
- **MEM, lw to GPIO_ADDR:** MDR←zext(gpio_i) with no bus request, then WB.
- **MEM, sw to GPIO_ADDR:** gpio_o←B with no bus request, then FETCH.
- **MEM, lw otherwise:** mem_req=1 at ALUOut. On ack: MDR←mem_rdata, go to WB.
- **MEM, sw otherwise:** mem_req=1, mem_we=1, mem_wdata=B. On ack: go to FETCH.
- **WB:** R[rd] for R-type, R[rt] for I-type ← ALUOut, or MDR for lw. Then FETCH.
- **Arithmetic:** modulo 2^WIDTH; no overflow exception on add/addi.
- **Unaligned addresses:** the low address bits are passed to the bus unchanged.
- **Watchdog:** the counter clears on entry to any state that requests the bus, and counts each edge with mem_req=1 and mem_ack=0. When it reaches TIMEOUT, go to TRAP with err_o=10.
- **TRAP:** mem_req=0. PC, registers and gpio_o are frozen. Only reset exits TRAP.

## Timing
- **Reset values** (next edge with reset=0, from any state, overriding an ack in the same cycle):
  - PC=RESET_PC, state_o=0 (FETCH).
  - All registers = 0, gpio_o=0, err_o=00.
  - mem_req=0 in the reset cycle.
- **Memory outputs:** mem_req, mem_we, mem_addr and mem_wdata are combinational from state and internal registers. They stay stable while waiting.
- **Request/ack:** mem_req falls in the cycle after ack. An ack with mem_req=0 is ignored.
- **Cycle counts with zero-wait memory:** R-type/addi/ori 4, lw 5, sw 4, beq and j 3, GPIO lw 5, GPIO sw 4.
- **Wait states:** each wait cycle adds 1 to FETCH or MEM.
- **Bus timeout:** with TIMEOUT=N, the core is in TRAP after N consecutive un-acked requested cycles.
- **Register write visibility:** a register written in WB is visible to the next instruction's DECODE.
- **GPIO visibility:** gpio_o updates on the MEM edge and is visible on the next cycle.

## Test plan
- Zero-wait memory; program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sw r3,0(r0) -> required response:
  - r3=2 and r4=1.
  - Write of 0x2 at address 0.
  - Cycle counts 4,4,4,4,4.
- ack delayed 3 cycles on every fetch -> required response:
  - Each instruction takes 3 extra cycles.
  - mem_addr is stable throughout each wait.
  - No trap.
- lw r5 from GPIO_ADDR with gpio_i=16'hA5A5, then sw r5 to GPIO_ADDR -> required response:
  - r5=32'h0000A5A5, then gpio_o=32'h0000A5A5.
  - mem_req stays 0 during both MEM states.
- beq r0,r0,-1 at 0x10 -> required response: PC loops back to 0x10 every 3 cycles. Then j 0x40 -> PC=0x100.
- Opcode 0x3F fetched -> required response: state_o=7 and err_o=01 after DECODE; mem_req=0 until reset.
- TIMEOUT=4 with mem_ack held 0 -> required response:
  - TRAP with err_o=10 after 4 cycles.
  - reset=0 for 1 edge mid-trap restores PC=RESET_PC, state_o=0 and err_o=00.

Source files
------------

// File: rtl/mc_core_hs.sv
// mc_core_hs: multicycle MIPS-subset core with a shared req/ack memory port,
// memory-mapped GPIO, a bus watchdog and a trap state.
module mc_core_hs #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      GPIO_W    = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] GPIO_ADDR = WIDTH'(32'hFFFF_0000),
    parameter int unsigned      TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [WIDTH-1:0]  gpio_o,
    output logic [2:0]        state_o,
    output logic [1:0]        err_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] gpio_q, gpio_d;
    logic [1:0]       err_q, err_d;
    logic [31:0]      wd_q, wd_d;
    logic [WIDTH-1:0] rf_q [32];

    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [WIDTH-1:0] rf_wd;
    logic             req;
    logic             we;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_z;
    logic             is_r;
    logic             is_addi;
    logic             is_ori;
    logic             is_lw;
    logic             is_sw;
    logic             is_beq;
    logic             is_j;
    logic             funct_ok;
    logic             legal;
    logic             gpio_hit;
    logic [WIDTH-1:0] alu_res;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign imm_s = WIDTH'($signed(ir_q[15:0]));
    assign imm_z = WIDTH'(ir_q[15:0]);

    assign is_r    = (op == 6'h00);
    assign is_addi = (op == 6'h08);
    assign is_ori  = (op == 6'h0D);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);

    assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    assign legal    = (is_r && funct_ok) || is_addi || is_ori
                    || is_lw || is_sw || is_beq || is_j;

    // GPIO is decoded on the word address; byte offset bits are ignored
    assign gpio_hit = (alu_q[WIDTH-1:2] == GPIO_ADDR[WIDTH-1:2]);

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            is_addi, is_lw, is_sw: alu_res = a_q + imm_s;
            is_ori:                alu_res = a_q | imm_z;
            is_r: begin
                unique case (funct)
                    6'h20:   alu_res = a_q + b_q;
                    6'h22:   alu_res = a_q - b_q;
                    6'h24:   alu_res = a_q & b_q;
                    6'h25:   alu_res = a_q | b_q;
                    6'h2A:   alu_res = WIDTH'($signed(a_q) < $signed(b_q));
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        gpio_d    = gpio_q;
        err_d     = err_q;
        wd_d      = '0;
        rf_we     = 1'b0;
        rf_wa     = rt;
        rf_wd     = alu_q;
        req       = 1'b0;
        we        = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;

        unique case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rs];
                b_d = rf_q[rt];
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    err_d   = 2'b01;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_beq: begin
                        if (a_q == b_q) begin
                            pc_d = pc_q + {imm_s[WIDTH-3:0], 2'b00};
                        end
                        state_d = S_FETCH;
                    end
                    is_j: begin
                        pc_d    = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
                    is_lw, is_sw: begin
                        alu_d   = alu_res;
                        state_d = S_MEM;
                    end
                    default: begin
                        alu_d   = alu_res;
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem_addr = alu_q;
                if (gpio_hit) begin
                    if (is_lw) begin
                        mdr_d   = WIDTH'(gpio_i);
                        state_d = S_WB;
                    end else begin
                        gpio_d  = b_q;
                        state_d = S_FETCH;
                    end
                end else begin
                    req = 1'b1;
                    we  = is_sw;
                    if (mem_ack) begin
                        if (is_lw) begin
                            mdr_d   = mem_rdata;
                            state_d = S_WB;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wa   = is_r ? rd : rt;
                rf_wd   = is_lw ? mdr_q : alu_q;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Watchdog counts consecutive un-acked request cycles only
        if (req && !mem_ack) begin
            wd_d = wd_q + 32'd1;
            if (TIMEOUT != 0 && wd_q == TIMEOUT - 1) begin
                state_d = S_TRAP;
                err_d   = 2'b10;
            end
        end
    end

    assign mem_req = req & reset;
    assign mem_we  = we;
    assign gpio_o  = gpio_q;
    assign state_o = state_q;
    assign err_o   = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            gpio_q  <= '0;
            err_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            gpio_q  <= gpio_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && rf_wa != 5'd0) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

endmodule
